// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encodings, oversampling constants
// and the parity helper used by the receive path.
package uart_pkg;

  localparam int OVERSAMPLE = 16;
  localparam int DATA_BITS  = 8;

  localparam logic [3:0] MID_TICK  = 4'd7;
  localparam logic [3:0] LAST_TICK = 4'd15;
  localparam logic [2:0] LAST_BIT  = 3'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    RX_IDLE   = 3'd0,
    RX_START  = 3'd1,
    RX_DATA   = 3'd2,
    RX_PARITY = 3'd3,
    RX_STOP   = 3'd4
  } rx_state_t;

  // Parity bit a correct frame carries: even -> XOR of data, odd -> XNOR.
  function automatic logic expected_parity(input logic [7:0] data, input logic even);
    return even ? (^data) : (~^data);
  endfunction

endpackage

// File: rtl/rx_fifo.sv
// Synchronous first-word-fall-through FIFO buffering received bytes.
// Writes while full are dropped and reported on ov_o; reads while empty are ignored.
module rx_fifo #(
  parameter int DATA_WIDTH    = 8,
  parameter int POINTER_WIDTH = 3
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  wr_i,
  input  logic [DATA_WIDTH-1:0] wr_data_i,
  input  logic                  rd_i,
  output logic [DATA_WIDTH-1:0] rd_data_o,
  output logic                  full_o,
  output logic                  empty_o,
  output logic                  ov_o
);

  localparam int DEPTH = 2 ** POINTER_WIDTH;

  logic [DATA_WIDTH-1:0]    mem [DEPTH];
  logic [POINTER_WIDTH-1:0] wr_ptr;
  logic [POINTER_WIDTH-1:0] rd_ptr;
  logic [POINTER_WIDTH:0]   count;
  logic                     do_wr;
  logic                     do_rd;

  // The count only reaches DEPTH when full, so its top bit is the full flag.
  assign full_o    = count[POINTER_WIDTH];
  assign empty_o   = (count == '0);
  assign do_wr     = wr_i & ~full_o;
  assign do_rd     = rd_i & ~empty_o;
  assign ov_o      = wr_i & full_o;
  assign rd_data_o = mem[rd_ptr];

  // Storage, pointers and occupancy; reset flushes contents so the head reads zero.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (do_wr) begin
        mem[wr_ptr] <= wr_data_i;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_rd) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({do_wr, do_rd})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/uart_receiver.sv
// UART receive path: 16x oversampled 8N1/8E1/8O1 deframer feeding an
// 8-entry FWFT FIFO, with sticky parity, framing and overrun flags.
module uart_receiver
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH    = 8,
  parameter int POINTER_WIDTH = 3
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  baud_tick_i,
  input  logic                  parity_en_i,
  input  logic                  even_parity_i,
  input  logic                  rx_i,
  input  logic                  rx_rd_i,
  input  logic                  err_clr_i,
  output logic [DATA_WIDTH-1:0] rx_data_o,
  output logic                  rx_empty_o,
  output logic                  rx_full_o,
  output logic                  rx_busy_o,
  output logic                  rx_overrun_o,
  output logic                  parity_err_o,
  output logic                  frame_err_o
);

  logic      rx_meta;
  logic      rx_s;
  rx_state_t state_q, state_d;
  logic [3:0] tick_q, tick_d;
  logic [2:0] bit_q, bit_d;
  logic [7:0] shift_q, shift_d;
  logic       par_en_q, par_en_d;
  logic       even_q, even_d;
  logic       perr_pend_q, perr_pend_d;
  logic       push_q, push_d;
  logic       frame_set;
  logic       perr_set;
  logic       fifo_ov;

  // Two-flop synchronizer for the asynchronous line; resets to the idle level.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx_i;
      rx_s    <= rx_meta;
    end
  end

  // Deframer state register, including counters, shifter and latched frame config.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= RX_IDLE;
      tick_q      <= '0;
      bit_q       <= '0;
      shift_q     <= '0;
      par_en_q    <= 1'b0;
      even_q      <= 1'b0;
      perr_pend_q <= 1'b0;
      push_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      tick_q      <= tick_d;
      bit_q       <= bit_d;
      shift_q     <= shift_d;
      par_en_q    <= par_en_d;
      even_q      <= even_d;
      perr_pend_q <= perr_pend_d;
      push_q      <= push_d;
    end
  end

  // Next-state logic; everything advances only on a baud tick, and
  // parity config is captured at mid start bit so later changes wait for the next frame.
  always_comb begin
    state_d     = state_q;
    tick_d      = tick_q;
    bit_d       = bit_q;
    shift_d     = shift_q;
    par_en_d    = par_en_q;
    even_d      = even_q;
    perr_pend_d = perr_pend_q;
    push_d      = 1'b0;
    frame_set   = 1'b0;
    perr_set    = 1'b0;
    if (baud_tick_i) begin
      tick_d = tick_q + 4'd1;
      unique case (state_q)
        RX_IDLE: begin
          tick_d = '0;
          if (!rx_s) begin
            state_d = RX_START;
          end
        end
        RX_START: begin
          if (tick_q == MID_TICK) begin
            tick_d = '0;
            if (!rx_s) begin
              state_d     = RX_DATA;
              bit_d       = '0;
              par_en_d    = parity_en_i;
              even_d      = even_parity_i;
              perr_pend_d = 1'b0;
            end else begin
              state_d = RX_IDLE;
            end
          end
        end
        RX_DATA: begin
          if (tick_q == LAST_TICK) begin
            shift_d = {rx_s, shift_q[7:1]};
            bit_d   = bit_q + 3'd1;
            if (bit_q == LAST_BIT) begin
              state_d = par_en_q ? RX_PARITY : RX_STOP;
            end
          end
        end
        RX_PARITY: begin
          if (tick_q == LAST_TICK) begin
            if (rx_s != expected_parity(shift_q, even_q)) begin
              perr_pend_d = 1'b1;
            end
            state_d = RX_STOP;
          end
        end
        RX_STOP: begin
          if (tick_q == LAST_TICK) begin
            state_d     = RX_IDLE;
            tick_d      = '0;
            perr_pend_d = 1'b0;
            if (rx_s) begin
              push_d   = 1'b1;
              perr_set = perr_pend_q;
            end else begin
              frame_set = 1'b1;
            end
          end
        end
        default: begin
          state_d = RX_IDLE;
          tick_d  = '0;
        end
      endcase
    end
  end

  // Sticky error flags; a set in the same cycle as a clear takes priority.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rx_overrun_o <= 1'b0;
      parity_err_o <= 1'b0;
      frame_err_o  <= 1'b0;
    end else begin
      rx_overrun_o <= fifo_ov   | (rx_overrun_o & ~err_clr_i);
      parity_err_o <= perr_set  | (parity_err_o & ~err_clr_i);
      frame_err_o  <= frame_set | (frame_err_o  & ~err_clr_i);
    end
  end

  assign rx_busy_o = (state_q != RX_IDLE);

  rx_fifo #(
    .DATA_WIDTH    (DATA_WIDTH),
    .POINTER_WIDTH (POINTER_WIDTH)
  ) u_rx_fifo (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .wr_i      (push_q),
    .wr_data_i (DATA_WIDTH'(shift_q)),
    .rd_i      (rx_rd_i),
    .rd_data_o (rx_data_o),
    .full_o    (rx_full_o),
    .empty_o   (rx_empty_o),
    .ov_o      (fifo_ov)
  );

endmodule

// File: tb/tb_uart_receiver.sv
// Directed self-checking bench for uart_receiver: good frames in each parity
// mode, false start, parity and framing errors, FIFO fill/overrun, mid-frame reset.
module tb_uart_receiver;

  logic       clk_i = 1'b0;
  logic       rst_i = 1'b1;
  logic       baud_tick_i = 1'b0;
  logic       parity_en_i = 1'b0;
  logic       even_parity_i = 1'b1;
  logic       rx_i = 1'b1;
  logic       rx_rd_i = 1'b0;
  logic       err_clr_i = 1'b0;
  logic [7:0] rx_data_o;
  logic       rx_empty_o;
  logic       rx_full_o;
  logic       rx_busy_o;
  logic       rx_overrun_o;
  logic       parity_err_o;
  logic       frame_err_o;

  int checkCount = 0;
  int passCount  = 0;
  int tickDiv    = 0;

  uart_receiver #(
    .DATA_WIDTH    (8),
    .POINTER_WIDTH (3)
  ) dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .baud_tick_i   (baud_tick_i),
    .parity_en_i   (parity_en_i),
    .even_parity_i (even_parity_i),
    .rx_i          (rx_i),
    .rx_rd_i       (rx_rd_i),
    .err_clr_i     (err_clr_i),
    .rx_data_o     (rx_data_o),
    .rx_empty_o    (rx_empty_o),
    .rx_full_o     (rx_full_o),
    .rx_busy_o     (rx_busy_o),
    .rx_overrun_o  (rx_overrun_o),
    .parity_err_o  (parity_err_o),
    .frame_err_o   (frame_err_o)
  );

  // 100 MHz-style clock
  always #5 clk_i = ~clk_i;

  // One baud tick every fourth clock, changed on the falling edge so it is stable at posedge
  always @(negedge clk_i) begin
    tickDiv     <= (tickDiv + 1) % 4;
    baud_tick_i <= (tickDiv == 3);
  end

  // Compare one observed value against its hand-computed expectation
  task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
    checkCount++;
    if (observed === expected) begin
      passCount++;
    end else begin
      $display("[TB] FAIL %s: observed %h, expected %h", tag, observed, expected);
    end
  endtask

  // Return at the posedge where the DUT sees the n-th baud tick
  task automatic waitTicks(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk_i);
      while (!baud_tick_i) @(posedge clk_i);
    end
  endtask

  task automatic sendBit(input logic b, input int ticks);
    #1 rx_i = b;
    waitTicks(ticks);
  endtask

  // Send one full frame LSB-first, then hold the line idle for a bit period
  task automatic applyStimulus(input logic [7:0] data, input logic useParity,
                               input logic parityBit, input logic stopBit);
    parity_en_i = useParity;
    waitTicks(1);
    sendBit(1'b0, 16);
    for (int i = 0; i < 8; i++) begin
      sendBit(data[i], 16);
    end
    if (useParity) begin
      sendBit(parityBit, 16);
    end
    sendBit(stopBit, 16);
    sendBit(1'b1, 16);
  endtask

  task automatic pulseRead();
    @(posedge clk_i); #1 rx_rd_i = 1'b1;
    @(posedge clk_i); #1 rx_rd_i = 1'b0;
  endtask

  task automatic pulseClear();
    @(posedge clk_i); #1 err_clr_i = 1'b1;
    @(posedge clk_i); #1 err_clr_i = 1'b0;
  endtask

  // Follow the first frame to its stop sample and check the push timing
  task automatic watchStop();
    int n;
    n = 0;
    while (!rx_busy_o && n < 400) begin
      @(posedge clk_i); #1; n++;
    end
    n = 0;
    while (rx_busy_o && n < 4000) begin
      @(posedge clk_i); #1; n++;
    end
    checkOutput("busy_falls_at_stop", 8'(rx_busy_o), 8'd0);
    checkOutput("empty_at_stop_edge", 8'(rx_empty_o), 8'd1);
    @(posedge clk_i); #1;
    checkOutput("empty_after_push", 8'(rx_empty_o), 8'd0);
    checkOutput("data_a5", rx_data_o, 8'hA5);
  endtask

  initial begin
    // Reset values
    repeat (3) @(posedge clk_i);
    #1;
    checkOutput("rst_empty", 8'(rx_empty_o), 8'd1);
    checkOutput("rst_full", 8'(rx_full_o), 8'd0);
    checkOutput("rst_busy", 8'(rx_busy_o), 8'd0);
    checkOutput("rst_overrun", 8'(rx_overrun_o), 8'd0);
    checkOutput("rst_perr", 8'(parity_err_o), 8'd0);
    checkOutput("rst_ferr", 8'(frame_err_o), 8'd0);
    checkOutput("rst_data", rx_data_o, 8'h00);
    rst_i = 1'b0;

    // 0xA5 even parity (parity bit 0), good stop
    even_parity_i = 1'b1;
    fork
      applyStimulus(8'hA5, 1'b1, 1'b0, 1'b1);
      watchStop();
    join
    checkOutput("a5_perr", 8'(parity_err_o), 8'd0);
    checkOutput("a5_ferr", 8'(frame_err_o), 8'd0);
    checkOutput("a5_overrun", 8'(rx_overrun_o), 8'd0);
    pulseRead();
    checkOutput("a5_drained", 8'(rx_empty_o), 8'd1);

    // False start: line low for 4 ticks only
    waitTicks(1);
    #1 rx_i = 1'b0;
    waitTicks(3);
    #1;
    checkOutput("false_start_busy", 8'(rx_busy_o), 8'd1);
    waitTicks(1);
    #1 rx_i = 1'b1;
    waitTicks(12);
    #1;
    checkOutput("false_start_idle", 8'(rx_busy_o), 8'd0);
    checkOutput("false_start_empty", 8'(rx_empty_o), 8'd1);

    // 0x01 even mode with wrong parity bit 0: byte kept, parity error flagged
    applyStimulus(8'h01, 1'b1, 1'b0, 1'b1);
    checkOutput("perr_set", 8'(parity_err_o), 8'd1);
    checkOutput("perr_data", rx_data_o, 8'h01);
    checkOutput("perr_not_empty", 8'(rx_empty_o), 8'd0);
    checkOutput("perr_no_ferr", 8'(frame_err_o), 8'd0);
    pulseClear();
    checkOutput("perr_cleared", 8'(parity_err_o), 8'd0);
    pulseRead();

    // 0x3C with low stop bit: discarded, framing error; then 0x55 received cleanly
    applyStimulus(8'h3C, 1'b1, 1'b0, 1'b0);
    checkOutput("ferr_set", 8'(frame_err_o), 8'd1);
    checkOutput("ferr_empty", 8'(rx_empty_o), 8'd1);
    applyStimulus(8'h55, 1'b1, 1'b0, 1'b1);
    checkOutput("after_ferr_data", rx_data_o, 8'h55);
    checkOutput("after_ferr_perr", 8'(parity_err_o), 8'd0);
    pulseClear();
    checkOutput("ferr_cleared", 8'(frame_err_o), 8'd0);
    pulseRead();
    checkOutput("after_ferr_drained", 8'(rx_empty_o), 8'd1);

    // Nine 8N1 frames with no reads: full after eight, ninth overruns
    for (int i = 0; i < 9; i++) begin
      applyStimulus(8'(i), 1'b0, 1'b0, 1'b1);
      if (i == 7) begin
        checkOutput("full_after_8", 8'(rx_full_o), 8'd1);
        checkOutput("no_overrun_at_8", 8'(rx_overrun_o), 8'd0);
      end
    end
    checkOutput("overrun_set", 8'(rx_overrun_o), 8'd1);
    for (int i = 0; i < 8; i++) begin
      checkOutput($sformatf("fifo_word_%0d", i), rx_data_o, 8'(i));
      pulseRead();
    end
    checkOutput("fifo_empty_after_reads", 8'(rx_empty_o), 8'd1);
    checkOutput("fifo_not_full", 8'(rx_full_o), 8'd0);
    pulseRead();
    checkOutput("read_when_empty_ignored", 8'(rx_empty_o), 8'd1);

    // Leave a byte in the FIFO and the overrun flag set, then reset during data bit 4
    even_parity_i = 1'b1;
    applyStimulus(8'h55, 1'b1, 1'b0, 1'b1);
    checkOutput("pre_reset_nonempty", 8'(rx_empty_o), 8'd0);
    even_parity_i = 1'b0;
    parity_en_i   = 1'b1;
    waitTicks(1);
    sendBit(1'b0, 16);
    sendBit(1'b0, 16);
    sendBit(1'b1, 16);
    sendBit(1'b1, 16);
    sendBit(1'b1, 16);
    #1 rx_i = 1'b1;
    waitTicks(8);
    #1 rst_i = 1'b1;
    @(posedge clk_i);
    #1 rst_i = 1'b0;
    checkOutput("midrst_busy", 8'(rx_busy_o), 8'd0);
    checkOutput("midrst_empty", 8'(rx_empty_o), 8'd1);
    checkOutput("midrst_full", 8'(rx_full_o), 8'd0);
    checkOutput("midrst_overrun", 8'(rx_overrun_o), 8'd0);
    checkOutput("midrst_perr", 8'(parity_err_o), 8'd0);
    checkOutput("midrst_ferr", 8'(frame_err_o), 8'd0);
    checkOutput("midrst_data", rx_data_o, 8'h00);
    rx_i = 1'b1;
    waitTicks(32);

    // 0x7E with odd parity: six ones, so the parity bit is 1
    applyStimulus(8'h7E, 1'b1, 1'b1, 1'b1);
    checkOutput("odd_7e_data", rx_data_o, 8'h7E);
    checkOutput("odd_7e_perr", 8'(parity_err_o), 8'd0);
    checkOutput("odd_7e_ferr", 8'(frame_err_o), 8'd0);
    checkOutput("odd_7e_nonempty", 8'(rx_empty_o), 8'd0);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
